// File: rtl/ariane_pkg.sv
// +----------------------------------------------------------------------+
// | ariane_pkg: shared types for the dcache flush arbiter                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ariane_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } flush_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_flush_arbiter_counter.sv
// +----------------------------------------------------------------------+
// | dcache_flush_arbiter_counter: up counter with sync clear and enable   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_flush_arbiter_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    // Clear has priority over enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_flush_arbiter.sv
// +----------------------------------------------------------------------+
// | dcache_flush_arbiter: merges fence/fence.i/fence.t flush requests     |
// | into one dcache flush with optional idle-drain phase.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_flush_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned      NrReq       = 3,
    parameter int unsigned      DrainCycles = 16,
    parameter logic [NrReq-1:0] DrainEn     = 3'b100
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] req_i,
    output logic [NrReq-1:0] ack_o,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    input  logic             cache_busy_i,
    output logic             stall_cache_o,
    output logic             busy_o,
    output logic [31:0]      flush_cnt_o
);

    localparam int unsigned CntW = $clog2(DrainCycles + 1);

    flush_arb_state_e  state;
    logic [NrReq-1:0]  serve_mask;
    logic [CntW-1:0]   drain_cnt;
    logic              need_drain;
    logic              drain_entry;
    logic              drain_done;
    logic              drain_sat;

    assign need_drain  = |(serve_mask & DrainEn);
    assign drain_entry = (state == FLUSH) && flush_dcache_ack_i && need_drain;
    assign drain_done  = (state == DRAIN) && !cache_busy_i &&
                         (drain_cnt == CntW'(DrainCycles - 1));
    // Saturating at DrainCycles keeps the counter from wrapping while unused.
    assign drain_sat   = (drain_cnt == CntW'(DrainCycles));

    dcache_flush_arbiter_counter #(
        .WIDTH (CntW)
    ) u_drain_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cache_busy_i | drain_entry),
        .en_i    (~drain_sat),
        .count_o (drain_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            serve_mask     <= '0;
            flush_cnt_o    <= '0;
            ack_o          <= '0;
            flush_dcache_o <= 1'b0;
            stall_cache_o  <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= '0;
                    if (|req_i) begin
                        serve_mask     <= req_i;
                        state          <= FLUSH;
                        flush_dcache_o <= 1'b1;
                        busy_o         <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_dcache_ack_i) begin
                        flush_dcache_o <= 1'b0;
                        if (need_drain) begin
                            state         <= DRAIN;
                            stall_cache_o <= 1'b1;
                        end else begin
                            state       <= ACK;
                            ack_o       <= serve_mask;
                            flush_cnt_o <= flush_cnt_o + 32'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state         <= ACK;
                        stall_cache_o <= 1'b0;
                        ack_o         <= serve_mask;
                        flush_cnt_o   <= flush_cnt_o + 32'd1;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    ack_o  <= '0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    serve_mask     <= '0;
                    ack_o          <= '0;
                    flush_dcache_o <= 1'b0;
                    stall_cache_o  <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_flush_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_dcache_flush_arbiter: directed self-checking bench                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dcache_flush_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic        flush_dc;
    logic        flush_dc_ack;
    logic        cache_busy;
    logic        stall;
    logic        busy;
    logic [31:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    dcache_flush_arbiter dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .ack_o              (ack),
        .flush_dcache_o     (flush_dc),
        .flush_dcache_ack_i (flush_dc_ack),
        .cache_busy_i       (cache_busy),
        .stall_cache_o      (stall),
        .busy_o             (busy),
        .flush_cnt_o        (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_ack, input logic e_flush,
                              input logic e_stall, input logic e_busy);
        check({tag, ".ack"},   {29'd0, ack},     {29'd0, e_ack});
        check({tag, ".flush"}, {31'd0, flush_dc}, {31'd0, e_flush});
        check({tag, ".stall"}, {31'd0, stall},    {31'd0, e_stall});
        check({tag, ".busy"},  {31'd0, busy},     {31'd0, e_busy});
    endtask

    initial begin
        int n;
        logic seen_ack;

        rst          = 1'b1;
        req          = 3'b000;
        flush_dc_ack = 1'b0;
        cache_busy   = 1'b0;
        tick();
        tick();
        check_outs("reset", 3'b000, 1'b0, 1'b0, 1'b0);
        check("reset.cnt", flush_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // Dcache ack outside FLUSH is ignored.
        flush_dc_ack = 1'b1;
        tick();
        check_outs("idle_ign", 3'b000, 1'b0, 1'b0, 1'b0);
        flush_dc_ack = 1'b0;

        // Single requester, dcache ack two cycles into FLUSH, no drain.
        req = 3'b001;
        tick();
        check_outs("t1.flush0", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("t1.flush1", 3'b000, 1'b1, 1'b0, 1'b1);
        flush_dc_ack = 1'b1;
        tick();
        check_outs("t1.ack", 3'b001, 1'b0, 1'b0, 1'b1);
        check("t1.cnt", flush_cnt, 32'd1);
        req = 3'b000;
        flush_dc_ack = 1'b0;
        tick();
        check_outs("t1.idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Two requesters together, minimum latency.
        req = 3'b011;
        flush_dc_ack = 1'b1;
        tick();
        check_outs("t2.flush", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("t2.ack", 3'b011, 1'b0, 1'b0, 1'b1);
        check("t2.cnt", flush_cnt, 32'd2);
        req = 3'b000;
        flush_dc_ack = 1'b0;
        tick();
        check_outs("t2.idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Drained flush: cache busy 5 cycles after dcache ack, then 16 idle cycles.
        req = 3'b100;
        tick();
        flush_dc_ack = 1'b1;
        cache_busy   = 1'b1;
        tick();
        check_outs("t3.drain", 3'b000, 1'b0, 1'b1, 1'b1);
        flush_dc_ack = 1'b0;
        req = 3'b000;
        tick();
        flush_dc_ack = 1'b1;
        tick();
        flush_dc_ack = 1'b0;
        tick();
        tick();
        check_outs("t3.busyph", 3'b000, 1'b0, 1'b1, 1'b1);
        cache_busy = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack != 3'b000) begin
                n = i;
                break;
            end
        end
        check("t3.latency", n, 32'd16);
        check_outs("t3.ack", 3'b100, 1'b0, 1'b0, 1'b1);
        check("t3.cnt", flush_cnt, 32'd3);
        tick();
        check_outs("t3.idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Busy pulse at idle count 10 restarts the drain count.
        req = 3'b100;
        tick();
        flush_dc_ack = 1'b1;
        tick();
        flush_dc_ack = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_outs("t4.mid", 3'b000, 1'b0, 1'b1, 1'b1);
        cache_busy = 1'b1;
        tick();
        cache_busy = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack != 3'b000) begin
                n = i;
                break;
            end
        end
        check("t4.latency", n, 32'd16);
        check("t4.ackval", {29'd0, ack}, 32'd4);
        check("t4.cnt", flush_cnt, 32'd4);
        req = 3'b000;
        tick();

        // Asynchronous reset in DRAIN.
        req = 3'b100;
        tick();
        flush_dc_ack = 1'b1;
        tick();
        flush_dc_ack = 1'b0;
        tick();
        tick();
        check_outs("t5.pre", 3'b000, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        req = 3'b000;
        #1;
        check_outs("t5.async", 3'b000, 1'b0, 1'b0, 1'b0);
        check("t5.cnt", flush_cnt, 32'd0);
        tick();
        rst = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            seen_ack = seen_ack | (|ack) | busy;
        end
        check("t5.noack", {31'd0, seen_ack}, 32'd0);

        // Late-rising request is served by a second operation.
        req = 3'b010;
        tick();
        check_outs("t6.flush", 3'b000, 1'b1, 1'b0, 1'b1);
        req = 3'b011;
        tick();
        flush_dc_ack = 1'b1;
        tick();
        check_outs("t6.ack1", 3'b010, 1'b0, 1'b0, 1'b1);
        check("t6.cnt1", flush_cnt, 32'd1);
        req = 3'b001;
        flush_dc_ack = 1'b0;
        tick();
        check_outs("t6.idle", 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("t6.flush2", 3'b000, 1'b1, 1'b0, 1'b1);
        flush_dc_ack = 1'b1;
        tick();
        check_outs("t6.ack2", 3'b001, 1'b0, 1'b0, 1'b1);
        check("t6.cnt2", flush_cnt, 32'd2);
        req = 3'b000;
        flush_dc_ack = 1'b0;
        tick();
        check_outs("t6.end", 3'b000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
